// File: rtl/delta_pkg.sv
// Shared helpers for the delta encode/decode sample path: signed clipping and
// frame-counter sizing.
package delta_pkg;

    // Bits needed to count 0..frame_len inclusive.
    function automatic int unsigned cnt_width(input int unsigned frame_len);
        return $clog2(frame_len + 1);
    endfunction

    // Clip val into the signed range of `width` bits; clipped reports whether it moved.
    function automatic longint sat_signed(input longint val, input int unsigned width,
                                          output logic clipped);
        longint max_v;
        longint min_v;
        max_v   = (longint'(1) <<< (width - 1)) - 1;
        min_v   = -max_v - 1;
        clipped = 1'b0;
        if (val > max_v) begin
            clipped = 1'b1;
            return max_v;
        end
        if (val < min_v) begin
            clipped = 1'b1;
            return min_v;
        end
        return val;
    endfunction

endpackage

// File: rtl/signed_saturate.sv
// Combinational signed clip from InWidth to OutWidth bits, shared by the encoder
// and decoder sides of the delta path.
module signed_saturate
    import delta_pkg::*;
#(
    parameter int unsigned InWidth  = 4,
    parameter int unsigned OutWidth = 4
) (
    input  logic signed [InWidth-1:0]  in_i,
    output logic signed [OutWidth-1:0] out_o,
    output logic                       sat_o
);

    always_comb begin
        sat_o = 1'b0;
        out_o = OutWidth'(sat_signed(longint'(in_i), OutWidth, sat_o));
    end

endmodule

// File: rtl/delta_encoder.sv
// Streaming signed delta encoder: emits sample - previous sample on a registered
// valid/ready stream, restarting the predictor on reset, restart and frame boundaries.
module delta_encoder
    import delta_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 3,
    parameter int unsigned OUT_WIDTH = 4,
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic signed [IN_WIDTH-1:0]  in_sample_i,
    input  logic                        restart_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic signed [OUT_WIDTH-1:0] out_delta_o,
    output logic                        out_first_o,
    output logic                        out_sat_o
);

    localparam int unsigned CntW  = cnt_width(FRAME_LEN);
    localparam int unsigned DiffW = IN_WIDTH + 1;
    localparam logic [CntW-1:0] FrameEnd = CntW'(FRAME_LEN);

    logic                        out_valid_q, out_valid_d;
    logic signed [OUT_WIDTH-1:0] out_delta_q, out_delta_d;
    logic                        out_first_q, out_first_d;
    logic                        out_sat_q, out_sat_d;
    logic signed [IN_WIDTH-1:0]  prev_q, prev_d;
    logic                        have_prev_q, have_prev_d;
    logic [CntW-1:0]             cnt_q, cnt_d;

    logic                        accept;
    logic                        first;
    logic signed [DiffW-1:0]     diff;
    logic signed [OUT_WIDTH-1:0] sat_val;
    logic                        sat_flag;
    logic [CntW-1:0]             cnt_inc;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    // A cleared predictor covers reset, restart and the frame wrap alike.
    assign first      = !have_prev_q || restart_i;
    assign diff       = DiffW'(in_sample_i) - (first ? {DiffW{1'b0}} : DiffW'(prev_q));
    assign cnt_inc    = first ? CntW'(1) : cnt_q + CntW'(1);

    signed_saturate #(
        .InWidth (DiffW),
        .OutWidth(OUT_WIDTH)
    ) u_sat (
        .in_i (diff),
        .out_o(sat_val),
        .sat_o(sat_flag)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_delta_d = out_delta_q;
        out_first_d = out_first_q;
        out_sat_d   = out_sat_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        cnt_d       = cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_delta_d = sat_val;
            out_first_d = first;
            out_sat_d   = sat_flag;
            prev_d      = in_sample_i;
            have_prev_d = 1'b1;
            cnt_d       = cnt_inc;
            if (cnt_inc == FrameEnd) begin
                cnt_d       = '0;
                have_prev_d = 1'b0;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_delta_q <= '0;
            out_first_q <= 1'b0;
            out_sat_q   <= 1'b0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_delta_q <= out_delta_d;
            out_first_q <= out_first_d;
            out_sat_q   <= out_sat_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_delta_o = out_delta_q;
    assign out_first_o = out_first_q;
    assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_delta_encoder.sv
// Scoreboard bench for delta_encoder: three configurations driven in lockstep
// (OUT_WIDTH 4 / FRAME_LEN 8, OUT_WIDTH 3 / FRAME_LEN 8, OUT_WIDTH 3 / FRAME_LEN 1).
module tb_delta_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid;
    logic              restart;
    logic              out_ready;
    logic signed [2:0] in_sample;

    logic              in_ready  [3];
    logic              out_valid [3];
    logic              out_first [3];
    logic              out_sat   [3];
    logic signed [3:0] delta_a;
    logic signed [2:0] delta_b;
    logic signed [2:0] delta_c;

    delta_encoder #(.IN_WIDTH(3), .OUT_WIDTH(4), .FRAME_LEN(8)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[0]),
        .in_sample_i(in_sample), .restart_i(restart), .out_valid_o(out_valid[0]),
        .out_ready_i(out_ready), .out_delta_o(delta_a), .out_first_o(out_first[0]),
        .out_sat_o(out_sat[0])
    );

    delta_encoder #(.IN_WIDTH(3), .OUT_WIDTH(3), .FRAME_LEN(8)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[1]),
        .in_sample_i(in_sample), .restart_i(restart), .out_valid_o(out_valid[1]),
        .out_ready_i(out_ready), .out_delta_o(delta_b), .out_first_o(out_first[1]),
        .out_sat_o(out_sat[1])
    );

    delta_encoder #(.IN_WIDTH(3), .OUT_WIDTH(3), .FRAME_LEN(1)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready[2]),
        .in_sample_i(in_sample), .restart_i(restart), .out_valid_o(out_valid[2]),
        .out_ready_i(out_ready), .out_delta_o(delta_c), .out_first_o(out_first[2]),
        .out_sat_o(out_sat[2])
    );

    typedef struct packed {
        logic signed [7:0] d;
        logic              f;
        logic              s;
    } exp_t;
    typedef exp_t [2:0] trio_t;

    trio_t sb[$];
    int    ow_tab[3] = '{4, 3, 3};
    int    fl_tab[3] = '{8, 8, 1};
    int    prev_m[3];
    int    cnt_m[3];
    bit    hp_m[3];
    int    n_checks = 0;
    int    n_pass = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic int obs_delta(input int i);
        case (i)
            0:       return int'(delta_a);
            1:       return int'(delta_b);
            default: return int'(delta_c);
        endcase
    endfunction

    task automatic model_reset();
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            prev_m[i] = 0;
            hp_m[i]   = 1'b0;
            cnt_m[i]  = 0;
        end
    endtask

    task automatic model_accept(input int i, input int s, input bit rs, output exp_t e);
        bit first;
        int diff;
        int mx;
        int mn;
        first = !hp_m[i] || rs;
        diff  = s - (first ? 0 : prev_m[i]);
        mx    = (1 << (ow_tab[i] - 1)) - 1;
        mn    = -mx - 1;
        e.f   = first;
        e.s   = 1'b0;
        e.d   = 8'(diff);
        if (diff > mx) begin
            e.d = 8'(mx);
            e.s = 1'b1;
        end else if (diff < mn) begin
            e.d = 8'(mn);
            e.s = 1'b1;
        end
        prev_m[i] = s;
        hp_m[i]   = 1'b1;
        cnt_m[i]  = first ? 1 : cnt_m[i] + 1;
        if (cnt_m[i] == fl_tab[i]) begin
            cnt_m[i] = 0;
            hp_m[i]  = 1'b0;
        end
    endtask

    task automatic check_outputs();
        trio_t h;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("out_valid[%0d]", i), int'(out_valid[i]), int'(sb.size() != 0));
            if (sb.size() != 0) begin
                h = sb[0];
                check_eq($sformatf("out_delta[%0d]", i), obs_delta(i), int'($signed(h[i].d)));
                check_eq($sformatf("out_first[%0d]", i), int'(out_first[i]), int'(h[i].f));
                check_eq($sformatf("out_sat[%0d]", i), int'(out_sat[i]), int'(h[i].s));
            end
        end
    endtask

    // One clock: check what the last edge produced, drive, then apply the model at the edge.
    task automatic step(input bit v, input int s, input bit rs, input bit rdy, input bit rst);
        bit    acc;
        bit    xfer;
        trio_t t;
        check_outputs();
        in_valid  = v;
        in_sample = 3'(s);
        restart   = rs;
        out_ready = rdy;
        rst_n     = rst;
        #1;
        for (int i = 0; i < 3; i++)
            check_eq($sformatf("in_ready[%0d]", i), int'(in_ready[i]),
                     int'(sb.size() == 0 || rdy));
        acc  = v && (sb.size() == 0 || rdy);
        xfer = (sb.size() != 0) && rdy;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (xfer) void'(sb.pop_front());
            if (acc) begin
                for (int i = 0; i < 3; i++) model_accept(i, s, rs, t[i]);
                sb.push_back(t);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_delta[%0d]", i), obs_delta(i), 0);
            check_eq($sformatf("rst_first[%0d]", i), int'(out_first[i]), 0);
            check_eq($sformatf("rst_sat[%0d]", i), int'(out_sat[i]), 0);
        end
    endtask

    int seq_a[4] = '{1, 3, -4, 3};
    int seq_b[3] = '{3, -4, 3};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        restart   = 1'b0;
        out_ready = 1'b1;
        in_sample = '0;
        model_reset();
        @(negedge clk);

        // Basic stream and saturation at narrower output widths.
        do_reset();
        foreach (seq_a[k]) step(1'b1, seq_a[k], 1'b0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1);

        do_reset();
        foreach (seq_b[k]) step(1'b1, seq_b[k], 1'b0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1);

        // Frame wrap: sample 9 starts a new frame.
        do_reset();
        repeat (9) step(1'b1, 2, 1'b0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1);

        // Restart with an accepted sample, then restart alone is ignored.
        do_reset();
        step(1'b1, 1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 2, 1'b0, 1'b1, 1'b1);
        step(1'b1, -3, 1'b1, 1'b1, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1);

        // Backpressure, then simultaneous transfer and accept.
        do_reset();
        step(1'b1, 2, 1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b1, -1, 1'b0, 1'b0, 1'b1);
        step(1'b1, -1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 3, 1'b0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1);

        // Reset while an output is held discards it.
        step(1'b1, 1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2, 1'b0, 1'b1, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1, 1'b1);

        // Random traffic with occasional restart and reset.
        do_reset();
        repeat (400) begin
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)) - 4,
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 40) != 0));
        end
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/delta_encoder.md
Name: delta_encoder

Overview:
- Streaming signed delta encoder, the encode-side counterpart of the team's signed adder/integrator path. Adder reconstructs samples via prev + delta; this block produces delta = sample − prev.
- Accepts signed samples on a valid/ready stream and emits registered signed differences on a valid/ready stream.
- The predictor (previous sample) is cleared at reset, on explicit restart, and automatically at frame boundaries.
- Sits in front of the adder-based decoder in the sample datapath.

Parameters:
IN_WIDTH, 3, signed input sample width (≥2)
OUT_WIDTH, 4, signed delta width; if < IN_WIDTH+1, result saturates
FRAME_LEN, 8, samples per frame before automatic predictor clear (≥1)

Ports:
clk  input  1  clock, all logic rising-edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  sample present
in_ready  output  1  block accepts sample this cycle
in_sample  input  IN_WIDTH  signed sample
restart  input  1  clear predictor; sampled only with accepted input
out_valid  output  1  delta present
out_ready  input  1  consumer accepts delta
out_delta  output  OUT_WIDTH  signed difference
out_first  output  1  delta is first of a frame (equals raw sample)
out_sat  output  1  delta was clipped

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, out_delta=0, out_first=0, out_sat=0, prev=0, have_prev=0, frame_cnt=0. Takes priority over all other activity, including a transfer in the same cycle; any held output is discarded.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single output register, no skid).
  - Input accepted when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - Output fields hold stable while out_valid && !out_ready.
- Latency: 1 cycle from accepted input to out_valid.
- Full throughput: 1 sample/cycle when out_ready is held high.
- On accepted input:
  - first = !have_prev || restart || (frame_cnt == FRAME_LEN−1 was passed, i.e. frame_cnt==0 with have_prev cleared).
  - diff (IN_WIDTH+1 bits, signed) = sext(in_sample) − (first ? 0 : sext(prev)).
  - If diff > 2^(OUT_WIDTH−1)−1: out_delta = max, out_sat = 1.
  - If diff < −2^(OUT_WIDTH−1): out_delta = min, out_sat = 1.
  - Otherwise out_delta = sext/trunc of diff, out_sat = 0.
  - Register: out_first = first, prev = in_sample (unsaturated raw sample, so the decoder drift is visible only via out_sat), have_prev = 1.
  - frame_cnt = first ? 1 : frame_cnt+1. When the new count equals FRAME_LEN: frame_cnt = 0 and have_prev = 0, so the next sample starts a frame.
- No accepted input, and output transfers: out_valid = 0. Other registers keep their values.
- restart with no accepted input: ignored (no sticky state).
- FRAME_LEN = 1: every sample is first, and out_delta = saturated sample.
- Simultaneous output transfer and input accept: out_valid stays 1, with new data.

Decomposition:
- Shared package delta_pkg:
  - sat_signed function (width-generic clip, returning the value and a clipped flag).
  - Frame-counter width constant: $clog2(FRAME_LEN+1).
- One natural sub-module, signed_saturate: combinational clip from IN_WIDTH+1 to OUT_WIDTH. Reused by the decoder side.
- The top holds the handshake, the predictor and the frame counter.

Test Plan:
- Reset then stream 1, 3, −4, 3 with out_ready=1 (defaults) -> deltas 1(first), 2, −7, 7; out_sat all 0; outputs on cycles 1–4 after the first accept.
- OUT_WIDTH=3, stream 3, −4, 3 -> 3(first), −4(sat=1, true −7), 3(sat=1, true 7).
- FRAME_LEN=8, stream 9 samples all value 2 -> first=1 on samples 1 and 9 with delta 2; deltas 0 on samples 2–8.
- restart=1 with the 3rd of samples 1, 2, −3 -> deltas 1(first), 1, −3(first); restart without in_valid has no effect.
- Backpressure: out_ready=0 for 3 cycles after one accepted sample -> in_ready=0, out_delta stable; out_ready=1 with in_valid=1 -> transfer and accept in the same cycle, out_valid stays 1.
- Assert rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0; next sample 2 emits first=1, delta 2.
